// File: rtl/start_signal_pio_in.sv
// rtl/start_signal_pio_in.sv - input-only PIO with synchronized edge capture and level interrupt
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   address     register word address: 0 data, 1 direction, 2 interruptmask, 3 edgecapture
//   chipselect  slave select, qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data, only the low WIDTH bits are used
//   in_port     asynchronous external status inputs
//   readdata    registered read data, updated every clock from the address mux
//   irq         level interrupt, OR of edgecapture & interruptmask
module start_signal_pio_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic [1:0]       prime_cnt;
    logic [WIDTH-1:0] interruptmask;
    logic [WIDTH-1:0] edgecapture;

    logic             primed;
    logic             wr_en;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wdata_w;
    logic [31:0]      rd_mux;

    // Upper writedata bits are deliberately dropped; fold them here so the
    // port is fully consumed.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wdata_w = writedata[WIDTH-1:0];
    assign wr_en   = chipselect && !write_n;

    // Edge detection is held off for the first three clocks after reset so
    // inputs already asserted at reset release ripple through s1..s3 without
    // being mistaken for edges.
    assign primed = (prime_cnt == 2'd3);

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = s2 & ~s3;
            1:       edge_raw = ~s2 & s3;
            default: edge_raw = s2 ^ s3;
        endcase
    end

    assign edge_det = primed ? edge_raw : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = s2;
            2'd1:    rd_mux = '0;
            2'd2:    rd_mux[WIDTH-1:0] = interruptmask;
            default: rd_mux[WIDTH-1:0] = edgecapture;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            prime_cnt     <= 2'd0;
            interruptmask <= '0;
            edgecapture   <= '0;
            readdata      <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            s3 <= s2;

            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end

            if (wr_en && (address == 2'd2)) begin
                interruptmask <= wdata_w;
            end

            // A new edge takes priority over a simultaneous write-1-to-clear.
            if (wr_en && (address == 2'd3)) begin
                edgecapture <= (edgecapture & ~wdata_w) | edge_det;
            end else begin
                edgecapture <= edgecapture | edge_det;
            end

            // Sampled from pre-write register values; no read strobe needed.
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & interruptmask);

endmodule

// File: tb/tb_start_signal_pio_in.sv
// tb/tb_start_signal_pio_in.sv - scoreboard bench for start_signal_pio_in
module tb_start_signal_pio_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int total;
    int bad;

    logic        rd_req;
    logic        rd_req_d;
    logic [31:0] exp_q[$];
    string       name_q[$];

    start_signal_pio_in #(
        .WIDTH(8),
        .EDGE_TYPE(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read requests become visible one clock later; the monitor pops the
    // expected value at the following falling edge.
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (rd_req_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow: got read with no expected value");
            end else begin
                check(name_q.pop_front(), readdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
        address = a;
        rd_req  = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        total      = 0;
        bad        = 0;
        rd_req     = 1'b0;
        rd_req_d   = 1'b0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;

        ticks(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);

        // Inputs high across reset release must not be captured.
        reset_n = 1'b1;
        ticks(10);
        do_read(2'd3, 32'h0, "prime_edgecapture");
        check("prime_irq", {31'h0, irq}, 32'h0);
        do_read(2'd0, 32'hFF, "data_ff");
        do_read(2'd1, 32'h0, "direction_zero");

        // Falling edges are ignored in rising mode.
        in_port = 8'h00;
        ticks(4);
        do_read(2'd3, 32'h0, "falling_ignored");

        // Rising edge on bit0 with mask bit0.
        do_write(2'd2, 32'hFFFF_FF01);
        do_read(2'd2, 32'h01, "mask_01_upper_ignored");
        in_port[0] = 1'b1;
        tick();
        tick();
        check("irq_before_e2", {31'h0, irq}, 32'h0);
        tick();
        check("irq_after_e2", {31'h0, irq}, 32'h1);
        do_read(2'd3, 32'h01, "edgecapture_bit0");
        do_read(2'd0, 32'h01, "data_bit0");

        // W1C clear, then a zero-bit clear leaves bit0 intact.
        do_write(2'd3, 32'h01);
        check("irq_after_clear", {31'h0, irq}, 32'h0);
        do_read(2'd3, 32'h0, "edgecapture_cleared");
        in_port[0] = 1'b0;
        ticks(3);
        in_port[0] = 1'b1;
        ticks(3);
        do_write(2'd3, 32'h02);
        do_read(2'd3, 32'h01, "w1c_other_bit");
        check("irq_still_set", {31'h0, irq}, 32'h1);
        do_write(2'd3, 32'h01);

        // Set wins over a coincident clear on bit3.
        in_port[3] = 1'b1;
        tick();
        tick();
        do_write(2'd3, 32'h08);
        do_read(2'd3, 32'h08, "set_beats_clear");
        do_write(2'd3, 32'h08);

        // Masked edges on bits 2 and 5, then unmask bit5.
        do_write(2'd2, 32'h00);
        in_port = in_port | 8'h24;
        ticks(3);
        do_read(2'd3, 32'h24, "edgecapture_24");
        check("irq_masked", {31'h0, irq}, 32'h0);
        do_write(2'd2, 32'h20);
        check("irq_unmasked", {31'h0, irq}, 32'h1);
        do_read(2'd2, 32'h20, "mask_20");

        // Fill edgecapture, then reset asynchronously between clock edges.
        do_write(2'd3, 32'hFF);
        do_write(2'd2, 32'hFF);
        in_port = 8'h00;
        ticks(3);
        in_port = 8'hFF;
        ticks(3);
        check("irq_all", {31'h0, irq}, 32'h1);
        do_read(2'd3, 32'hFF, "edgecapture_ff");
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", readdata, 32'h0);
        check("async_reset_irq", {31'h0, irq}, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        do_read(2'd2, 32'h0, "mask_after_reset");
        do_read(2'd3, 32'h0, "edgecapture_after_reset");
        ticks(8);
        do_read(2'd3, 32'h0, "no_residual_capture");
        check("irq_after_reset", {31'h0, irq}, 32'h0);

        ticks(2);
        check("scoreboard_empty", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/start_signal_pio_in.md
START_SIGNAL_PIO_IN -- requirements
Module: start_signal_pio_in

Interface
REQ-001 Parameter WIDTH, default 8, number of input port bits (1..32).
REQ-002 Parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM word address of the register.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-008 writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-009 in_port  input  WIDTH  asynchronous external status inputs.
REQ-010 readdata  output  32  registered read data; bits above WIDTH-1 always 0.
REQ-011 irq  output  1  active-high level interrupt.

Function
REQ-012 Register map SHALL be: 0 data (RO), 1 direction (RO, reads 0), 2 interruptmask (RW), 3 edgecapture (RO, write-1-to-clear per bit).
REQ-013 in_port SHALL pass through a two-flop synchronizer (s1, s2) plus a third history flop (s3); no other logic SHALL sample in_port.
REQ-014 Per-bit edge detect SHALL be: rising s2&~s3, falling ~s2&s3, any s2^s3, selected by EDGE_TYPE.
REQ-015 A detected edge SHALL set the edgecapture bit on the next clk edge; the bit SHALL hold until cleared or reset.
REQ-016 Edge timing: in_port changes before edge E0 -> s1 at E0, s2 at E1, edgecapture bit set at E2.
REQ-017 A 2-bit prime counter SHALL count from 0 to 3 after reset release and saturate; edge detection SHALL be disabled while count < 3, so inputs already high at reset release create no capture.
REQ-018 Write occurs when chipselect=1 and write_n=0 at a clk edge; address 0 and 1 writes SHALL be ignored.
REQ-019 Address 2 write SHALL load interruptmask <= writedata[WIDTH-1:0].
REQ-020 Address 3 write SHALL clear each edgecapture bit whose writedata bit is 1; bits with 0 are unchanged.
REQ-021 Same-cycle edge detect and W1C clear on one bit: set SHALL win (bit remains 1).
REQ-022 readdata SHALL be registered every clk from the address mux (no read strobe): 0 -> s2, 1 -> 0, 2 -> interruptmask, 3 -> edgecapture; latency exactly 1 cycle.
REQ-023 readdata SHALL reflect register contents before any write in the same cycle.
REQ-024 irq SHALL equal OR over (edgecapture & interruptmask), combinational from registers, no added latency.
REQ-025 No chipselect gating on readdata; chipselect=0 SHALL NOT block readdata updates.

Reset
REQ-026 On reset_n=0, immediately and asynchronously: s1, s2, s3, prime counter, interruptmask, edgecapture, readdata SHALL be 0; irq SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard pending edges and mask with no residual capture after release.
REQ-028 Operation SHALL resume on the first clk edge after reset_n deasserts; prime window per REQ-017 applies.

Verification
REQ-029 Reset with in_port=8'hFF, release, hold 10 cycles, read addr 3 -> readdata 0, irq 0.
REQ-030 EDGE_TYPE=0, mask=8'h01, in_port bit0 0->1 before E0 -> edgecapture=8'h01 and irq=1 after E2; read addr 0 -> 8'h01 one cycle later.
REQ-031 Write addr 3 data 8'h01 -> edgecapture 0, irq 0 next cycle; write 8'h02 with bit0 set -> bit0 stays 1.
REQ-032 Rising edge on bit3 coincident with W1C write 8'h08 -> edgecapture bit3 = 1 after the cycle.
REQ-033 Edges on bits 2 and 5 with mask=8'h00 -> edgecapture=8'h24, irq=0; write mask 8'h20 -> irq=1 same cycle mask updates.
REQ-034 Set edgecapture=8'hFF, assert reset_n=0 mid-cycle -> readdata, edgecapture, mask, irq all 0 without clock edge.
